reaction_sequencer: RTL and testbench
=====================================

Name: reaction_sequencer

Overview:
- Top-level mode controller for the reaction-timer game. It produces the 3-bit `state` bus that `state_decoder` turns into one-hot stage enables.
- It sequences a round: idle, random arming delay, millisecond counting, result hold, and a fault state for an early press.
- It owns the ms prescaler, the random-delay LFSR, the reaction counter and the best-time register. Display logic downstream reads these values.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock).
- MIN_DELAY_MS, 1000, fixed part of the arming delay, in ms; must be >= 1.
- DELAY_MASK, 2047, AND-mask applied to LFSR[15:0] for the random part of the delay.
- MAX_COUNT, 9999, saturation and timeout value of the reaction count, in ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse from the debounced start key.
- stop  in  1  single-cycle pulse from the debounced reaction key.
- state  out  3  current mode: 0 IDLE, 1 ARMED, 2 COUNTING, 3 RESULT, 4 FAULT.
- count_ms  out  14  live or frozen reaction time, in ms.
- best_ms  out  14  best (lowest) valid time since reset.
- timeout  out  1  high in RESULT when the round ended by saturation.
- new_best  out  1  high in RESULT when this round updated best_ms.

Behaviour:
- Clocking and reset
  - All state is updated on the rising clk edge; every output is registered.
  - Reset is synchronous: rst_n low at an edge sets state=0, count_ms=0, best_ms=MAX_COUNT, timeout=0, new_best=0, prescaler=0, delay_cnt=0, LFSR=16'hACE1.
  - Reset asserted mid-round aborts the round with the same values; there is no partial state.
- LFSR
  - 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle including IDLE, and never reaches zero.
- Prescaler and tick
  - The prescaler clears on every state entry, then counts 0..TICK_DIV-1.
  - tick is asserted in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- IDLE
  - start -> ARMED, with delay_cnt loaded as MIN_DELAY_MS + (LFSR & DELAY_MASK).
  - stop is ignored.
- ARMED
  - stop -> FAULT. stop has priority over tick and start.
  - Otherwise, on tick: delay_cnt decrements. If delay_cnt==1 on that tick -> COUNTING with count_ms=0.
  - ARMED therefore lasts exactly delay*TICK_DIV cycles.
  - start is ignored.
- COUNTING
  - On tick: count_ms increments.
  - On a tick where count_ms==MAX_COUNT-1, count_ms becomes MAX_COUNT and the next state is RESULT with timeout=1; best_ms is not updated.
  - stop -> RESULT with count_ms frozen. stop has priority if it coincides with a tick, so that tick's increment is dropped.
  - On that stop: if count_ms < best_ms, then best_ms <= count_ms and new_best=1.
- RESULT
  - count_ms, timeout and new_best hold.
  - start -> ARMED (new delay loaded; count_ms, timeout and new_best cleared).
  - stop is ignored.
- FAULT
  - count_ms holds its last value.
  - start -> IDLE with count_ms=0. stop is ignored.
- Simultaneous start and stop
  - ARMED and COUNTING: stop wins.
  - IDLE, RESULT and FAULT: start wins.
- Encoding
  - state never takes values 5-7. Illegal values recover to IDLE on the next edge.
- Arithmetic
  - All counters are unsigned.
  - delay_cnt is 16 bits and must not overflow with the default parameters.
  - count_ms never exceeds MAX_COUNT.

Decomposition:
- Package `reaction_pkg` holds:
  - the state encoding constants (S_IDLE=0, S_ARMED=1, S_COUNTING=2, S_RESULT=3, S_FAULT=4), matching the `state_decoder` input;
  - the LFSR seed and taps;
  - the count width (14).
- One natural sub-module: `ms_tick_gen` — the prescaler, with inputs clear and output tick, parameterised by TICK_DIV.
- The FSM, LFSR, delay counter and best-time register stay in `reaction_sequencer`.

Test Plan:
The bench uses TICK_DIV=4, MIN_DELAY_MS=3, DELAY_MASK=0, MAX_COUNT=20.
1. Reset, then start pulse -> state=1 on the next edge; state=2 exactly 12 cycles later; count_ms=0 on entry.
2. In COUNTING, stop after 5 ticks (20 cycles) -> state=3, count_ms=5, best_ms=5, new_best=1, timeout=0.
3. Second round: start from RESULT, stop at 7 ticks -> count_ms=7, best_ms stays 5, new_best=0.
4. stop during ARMED (cycle 6 of 12) -> state=4, count_ms unchanged; then start -> state=0 with count_ms=0.
5. No stop in COUNTING -> after 20 ticks (80 cycles): state=3, count_ms=20, timeout=1, best_ms unchanged.
6. Collision and reset cases:
   - stop coincident with a tick at count_ms=3 -> count_ms=3 frozen.
   - start and stop in the same cycle in IDLE -> state=1.
   - rst_n low during COUNTING -> next edge state=0, count_ms=0, best_ms=20.

Source files
------------

// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_pkg
// Description : Shared definitions for the reaction-timer mode controller:
//               state encoding (matches the state_decoder input), LFSR seed
//               and tap mask, and the reaction-count width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_COUNTING = 3'd2,
        S_RESULT   = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    localparam int unsigned c_COUNT_W = 14;

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Millisecond prescaler. Counts 0..TICK_DIV-1 and asserts
//               o_tick while the count sits at TICK_DIV-1, then wraps.
//               i_clear restarts the count from zero at the next edge.
// Ports       : clk     - system clock
//               rst_n   - synchronous reset, active-low
//               i_clear - restart the prescaler (used on every state entry)
//               o_tick  - one-cycle tick every TICK_DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned     c_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(TICK_DIV - 1);

    logic [c_W-1:0] r_presc;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_presc <= '0;
        end else if (o_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign o_tick = (r_presc == c_LAST);

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/reaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reaction_sequencer
// Description : Mode controller for the reaction-timer game. Sequences a
//               round (idle, random arming delay, ms counting, result hold,
//               early-press fault) and owns the LFSR, delay counter,
//               reaction counter and best-time register.
// Ports       : clk      - system clock
//               rst_n    - synchronous reset, active-low
//               start    - single-cycle start key pulse
//               stop     - single-cycle reaction key pulse
//               state    - 0 IDLE, 1 ARMED, 2 COUNTING, 3 RESULT, 4 FAULT
//               count_ms - live or frozen reaction time (ms)
//               best_ms  - lowest valid time since reset (ms)
//               timeout  - RESULT reached by saturation
//               new_best - RESULT round improved best_ms
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_sequencer
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_MASK   = 2047,
    parameter int unsigned MAX_COUNT    = 9999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    output logic [2:0]           state,
    output logic [c_COUNT_W-1:0] count_ms,
    output logic [c_COUNT_W-1:0] best_ms,
    output logic                 timeout,
    output logic                 new_best
);

    localparam logic [c_COUNT_W-1:0] c_MAX    = c_COUNT_W'(MAX_COUNT);
    localparam logic [c_COUNT_W-1:0] c_MAX_M1 = c_COUNT_W'(MAX_COUNT - 1);

    state_t                 r_state, w_state_nxt;
    logic [15:0]            r_lfsr;
    logic [15:0]            r_delay, w_delay_nxt;
    logic [c_COUNT_W-1:0]   r_count, w_count_nxt;
    logic [c_COUNT_W-1:0]   r_best, w_best_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic                   r_new_best, w_new_best_nxt;

    logic                   w_tick;
    logic                   w_lfsr_fb;
    logic [15:0]            w_delay_load;

    // Prescaler restarts whenever the FSM moves to a different state, so
    // every state sees its first tick exactly TICK_DIV cycles after entry.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_state_nxt != r_state),
        .o_tick  (w_tick)
    );

    assign w_lfsr_fb    = ^(r_lfsr & c_LFSR_TAPS);
    assign w_delay_load = 16'(MIN_DELAY_MS) + (r_lfsr & 16'(DELAY_MASK));

    always_comb begin
        w_state_nxt    = r_state;
        w_delay_nxt    = r_delay;
        w_count_nxt    = r_count;
        w_best_nxt     = r_best;
        w_timeout_nxt  = r_timeout;
        w_new_best_nxt = r_new_best;

        case (r_state)
            S_IDLE, S_RESULT: begin
                // start wins over a coincident stop here; stop alone is ignored.
                if (start) begin
                    w_state_nxt    = S_ARMED;
                    w_delay_nxt    = w_delay_load;
                    w_count_nxt    = '0;
                    w_timeout_nxt  = 1'b0;
                    w_new_best_nxt = 1'b0;
                end
            end
            S_ARMED: begin
                if (stop) begin
                    w_state_nxt = S_FAULT;
                end else if (w_tick) begin
                    w_delay_nxt = r_delay - 16'd1;
                    if (r_delay == 16'd1) begin
                        w_state_nxt = S_COUNTING;
                        w_count_nxt = '0;
                    end
                end
            end
            S_COUNTING: begin
                // A stop on a tick cycle drops that tick's increment.
                if (stop) begin
                    w_state_nxt = S_RESULT;
                    if (r_count < r_best) begin
                        w_best_nxt     = r_count;
                        w_new_best_nxt = 1'b1;
                    end
                end else if (w_tick) begin
                    if (r_count >= c_MAX_M1) begin
                        w_count_nxt   = c_MAX;
                        w_state_nxt   = S_RESULT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (start) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= c_LFSR_SEED;
            r_delay    <= '0;
            r_count    <= '0;
            r_best     <= c_MAX;
            r_timeout  <= 1'b0;
            r_new_best <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
            r_delay    <= w_delay_nxt;
            r_count    <= w_count_nxt;
            r_best     <= w_best_nxt;
            r_timeout  <= w_timeout_nxt;
            r_new_best <= w_new_best_nxt;
        end
    end

    assign state    = r_state;
    assign count_ms = r_count;
    assign best_ms  = r_best;
    assign timeout  = r_timeout;
    assign new_best = r_new_best;

endmodule : reaction_sequencer
`default_nettype wire

// File: tb/tb_reaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_sequencer
// Description : Self-checking bench for reaction_sequencer with small
//               parameters (TICK_DIV=4, MIN_DELAY_MS=3, DELAY_MASK=0,
//               MAX_COUNT=20). A vector table walks full rounds; hand-written
//               sequences cover stop/tick collision, start+stop collisions
//               and reset mid-round.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [2:0]  state;
    logic [13:0] count_ms;
    logic [13:0] best_ms;
    logic        timeout;
    logic        new_best;

    int n_checks = 0;
    int n_fail   = 0;

    reaction_sequencer #(
        .TICK_DIV     (4),
        .MIN_DELAY_MS (3),
        .DELAY_MASK   (0),
        .MAX_COUNT    (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .state    (state),
        .count_ms (count_ms),
        .best_ms  (best_ms),
        .timeout  (timeout),
        .new_best (new_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        sp;
        int          idle;
        logic [2:0]  e_state;
        logic [13:0] e_count;
        logic [13:0] e_best;
        logic        e_to;
        logic        e_nb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic s, input logic p, input int n,
                       input int es, input int ec, input int eb,
                       input logic et, input logic en);
        vec_t v;
        v.name    = nm;
        v.st      = s;
        v.sp      = p;
        v.idle    = n;
        v.e_state = 3'(es);
        v.e_count = 14'(ec);
        v.e_best  = 14'(eb);
        v.e_to    = et;
        v.e_nb    = en;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input string field, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, exp_v);
        end
    endtask

    // Called at a negedge; compares all outputs.
    task automatic check(input string nm, input int es, input int ec, input int eb,
                         input logic et, input logic en);
        cmp(nm, "state",    (^state    === 1'bx) ? -1 : int'(state),    es);
        cmp(nm, "count_ms", (^count_ms === 1'bx) ? -1 : int'(count_ms), ec);
        cmp(nm, "best_ms",  (^best_ms  === 1'bx) ? -1 : int'(best_ms),  eb);
        cmp(nm, "timeout",  (timeout  === 1'bx) ? -1 : int'(timeout),  int'(et));
        cmp(nm, "new_best", (new_best === 1'bx) ? -1 : int'(new_best), int'(en));
    endtask

    // Apply start/stop for one edge, then n further edges with inputs low.
    task automatic run(input logic s, input logic p, input int n);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Round 1: arming delay is 3 ms = 12 cycles; stop after 5 ticks.
        add("arm_entry",       1, 0,  0, 1,  0, 20, 0, 0);
        add("armed_11",        0, 0, 10, 1,  0, 20, 0, 0);
        add("count_entry",     0, 0,  0, 2,  0, 20, 0, 0);
        add("count_5",         0, 0, 19, 2,  5, 20, 0, 0);
        add("stop_5",          0, 1,  0, 3,  5,  5, 0, 1);
        add("hold_result",     0, 0,  3, 3,  5,  5, 0, 1);
        // Round 2: slower time does not replace the best.
        add("rearm",           1, 0,  0, 1,  0,  5, 0, 0);
        add("count_entry2",    0, 0, 11, 2,  0,  5, 0, 0);
        add("count_7",         0, 0, 27, 2,  7,  5, 0, 0);
        add("stop_7",          0, 1,  0, 3,  7,  5, 0, 0);
        // Early press during the arming delay.
        add("arm3",            1, 0,  0, 1,  0,  5, 0, 0);
        add("armed_5",         0, 0,  4, 1,  0,  5, 0, 0);
        add("early_stop",      0, 1,  0, 4,  0,  5, 0, 0);
        add("fault_stop_ign",  0, 1,  2, 4,  0,  5, 0, 0);
        add("fault_to_idle",   1, 0,  0, 0,  0,  5, 0, 0);
        add("idle_stop_ign",   0, 1,  1, 0,  0,  5, 0, 0);
        // No reaction: saturate at MAX_COUNT after 80 cycles.
        add("arm4",            1, 0,  0, 1,  0,  5, 0, 0);
        add("count_entry4",    0, 0, 11, 2,  0,  5, 0, 0);
        add("count_19",        0, 0, 78, 2, 19,  5, 0, 0);
        add("timeout",         0, 0,  0, 3, 20,  5, 1, 0);
        add("result_stop_ign", 0, 1,  0, 3, 20,  5, 1, 0);

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset", 0, 0, 20, 0, 0);

        foreach (vecs[i]) begin
            run(vecs[i].st, vecs[i].sp, vecs[i].idle);
            check(vecs[i].name, int'(vecs[i].e_state), int'(vecs[i].e_count),
                  int'(vecs[i].e_best), vecs[i].e_to, vecs[i].e_nb);
        end

        // Stop lands on the tick cycle that would take count 3 -> 4.
        run(1, 0, 0);
        run(0, 0, 11);
        check("coll_count_entry", 2, 0, 5, 0, 0);
        run(0, 0, 14);
        check("coll_pre", 2, 3, 5, 0, 0);
        run(0, 1, 0);
        check("coll_stop_tick", 3, 3, 3, 0, 1);

        // Start+stop collisions: start wins in IDLE, stop wins in ARMED.
        run(1, 0, 0);
        run(0, 1, 0);
        run(1, 0, 0);
        check("back_to_idle", 0, 0, 3, 0, 0);
        run(1, 1, 0);
        check("idle_start_stop", 1, 0, 3, 0, 0);
        run(1, 1, 0);
        check("armed_start_stop", 4, 0, 3, 0, 0);

        // Reset in the middle of counting.
        run(1, 0, 0);
        run(1, 0, 0);
        run(0, 0, 11);
        check("count_entry5", 2, 0, 3, 0, 0);
        run(0, 0, 9);
        check("count_2", 2, 2, 3, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_reset", 0, 0, 20, 0, 0);
        run(0, 0, 2);
        check("post_reset_idle", 0, 0, 20, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reaction_sequencer
`default_nettype wire
